// File: rtl/sobel_result_sink_if.sv
// Handshake and read-back signals between the Sobel core / host and the result sink.
// The master side is whatever drives the pixel stream and reads the frame back.
interface sobel_result_sink_if #(
    parameter int ADDR_W = 16
);
    logic              Start;
    logic [1:0]        SobelState;
    logic              isReady;
    logic              Finish;
    logic              Dop;
    logic [7:0]        Gradient;
    logic [ADDR_W-1:0] RdAddr;
    logic [ADDR_W-4:0] RdEdgeAddr;
    logic [7:0]        RdGradient;
    logic [7:0]        RdEdgeByte;
    logic              Busy;
    logic              Done;
    logic [ADDR_W:0]   PixelCount;
    logic [ADDR_W:0]   EdgeCount;

    modport master (
        output Start, SobelState, isReady, Finish, Dop, Gradient, RdAddr, RdEdgeAddr,
        input  RdGradient, RdEdgeByte, Busy, Done, PixelCount, EdgeCount
    );

    modport slave (
        input  Start, SobelState, isReady, Finish, Dop, Gradient, RdAddr, RdEdgeAddr,
        output RdGradient, RdEdgeByte, Busy, Done, PixelCount, EdgeCount
    );
endinterface

// File: rtl/sobel_result_sink.sv
// Captures one Sobel output frame: gradients into a pixel RAM, edge bits packed
// MSB-first into a byte RAM, with a registered read port for dumping the result.
module sobel_result_sink #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    sobel_result_sink_if.slave bus
);
    localparam int              NPIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W+1)'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
    state_t state, state_next;

    logic [7:0] grad_ram [2**ADDR_W];
    logic [7:0] edge_ram [2**(ADDR_W-3)];

    logic [ADDR_W:0] pixel_count, edge_count;
    logic [7:0]      shift_byte;
    logic [2:0]      bit_idx;
    logic            finish_q;

    logic            cap, finish_rise;
    logic            arm, take, edge_we;
    logic [7:0]      shift_with_dop, edge_wdata;
    logic [ADDR_W-4:0] edge_waddr;

    assign cap            = bus.isReady & ~bus.Finish & (bus.SobelState == 2'd2);
    assign finish_rise    = bus.Finish & ~finish_q;
    assign shift_with_dop = shift_byte | (8'(bus.Dop) << (3'd7 - bit_idx));
    assign edge_waddr     = pixel_count[ADDR_W-1:3];

    always_comb begin
        state_next = state;
        arm        = 1'b0;
        take       = 1'b0;
        edge_we    = 1'b0;
        edge_wdata = shift_with_dop;
        case (state)
            IDLE, DONE: begin
                if (bus.Start) begin
                    state_next = CAPTURE;
                    arm        = 1'b1;
                end
            end
            CAPTURE: begin
                if (cap) begin
                    take    = 1'b1;
                    edge_we = (bit_idx == 3'd7);
                    if (pixel_count == LAST_PIX) state_next = DONE;
                end else if (finish_rise) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Partial byte: bits not yet shifted in are already zero.
                edge_we    = (bit_idx != 3'd0);
                edge_wdata = shift_byte;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            pixel_count <= '0;
            edge_count  <= '0;
            shift_byte  <= '0;
            bit_idx     <= '0;
            finish_q    <= 1'b0;
        end else begin
            state    <= state_next;
            finish_q <= bus.Finish;
            if (arm) begin
                pixel_count <= '0;
                edge_count  <= '0;
                shift_byte  <= '0;
                bit_idx     <= '0;
            end else if (take) begin
                pixel_count <= pixel_count + 1'b1;
                edge_count  <= edge_count + (ADDR_W+1)'(bus.Dop);
                shift_byte  <= (bit_idx == 3'd7) ? 8'h00 : shift_with_dop;
                bit_idx     <= bit_idx + 1'b1;
            end
        end
    end

    // NOTE: RAM arrays carry no reset, so they map onto block RAM; only the read registers reset.
    always_ff @(posedge CLK) begin
        if (take)    grad_ram[pixel_count[ADDR_W-1:0]] <= bus.Gradient;
        if (edge_we) edge_ram[edge_waddr]              <= edge_wdata;
    end

    // Reads sample the array before this edge's write lands, giving read-old-data.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            bus.RdGradient <= '0;
            bus.RdEdgeByte <= '0;
        end else begin
            bus.RdGradient <= grad_ram[bus.RdAddr];
            bus.RdEdgeByte <= edge_ram[bus.RdEdgeAddr];
        end
    end

    assign bus.Busy       = (state == CAPTURE) || (state == FLUSH);
    assign bus.Done       = (state == DONE);
    assign bus.PixelCount = pixel_count;
    assign bus.EdgeCount  = edge_count;
endmodule

// File: tb/tb_sobel_result_sink.sv
// Randomized bench for sobel_result_sink on a reduced 16x8 frame, checked against
// a per-pixel frame model kept as plain arrays.
module tb_sobel_result_sink;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = 7;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBYTE  = NPIX / 8;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    sobel_result_sink_if #(.ADDR_W(ADDR_W)) bus();

    sobel_result_sink #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: what the frame memory and counters should hold.
    int grad_m  [NPIX];
    bit gvalid  [NPIX];
    int edge_m  [NBYTE];
    bit evalid  [NBYTE];
    bit frame_dop [NPIX];
    int  m_cnt = 0, m_edges = 0;
    bit  m_capturing = 0, m_flush = 0, m_done = 0, m_fin_prev = 0;

    function automatic int pack(input int base, input int n);
        int b = 0;
        for (int j = 0; j < n; j++) if (frame_dop[base + j]) b |= (1 << (7 - j));
        return b;
    endfunction

    // One clock: drive inputs at negedge, advance the model, check #1 after posedge.
    task automatic step(input bit rst, input bit start, input logic [1:0] ss, input bit rdy,
                        input bit fin, input bit dop, input logic [7:0] g,
                        input int ra, input int rea);
        int  exp_rg, exp_re;
        bit  v_rg, v_re, strobe, fin_rise;
        @(negedge CLK);
        Reset          = rst;
        bus.Start      = start;
        bus.SobelState = ss;
        bus.isReady    = rdy;
        bus.Finish     = fin;
        bus.Dop        = dop;
        bus.Gradient   = g;
        bus.RdAddr     = ra[ADDR_W-1:0];
        bus.RdEdgeAddr = rea[ADDR_W-4:0];

        if (rst) begin
            exp_rg = 0; v_rg = 1; exp_re = 0; v_re = 1;
        end else begin
            exp_rg = grad_m[ra]; v_rg = gvalid[ra];
            exp_re = edge_m[rea]; v_re = evalid[rea];
        end

        strobe   = rdy && !fin && (ss == 2'd2);
        fin_rise = fin && !m_fin_prev;
        m_fin_prev = fin;
        if (rst) begin
            m_capturing = 0; m_flush = 0; m_done = 0; m_cnt = 0; m_edges = 0; m_fin_prev = 0;
        end else if (m_flush) begin
            if (m_cnt % 8 != 0) begin
                edge_m[m_cnt / 8] = pack(m_cnt - m_cnt % 8, m_cnt % 8);
                evalid[m_cnt / 8] = 1;
            end
            m_flush = 0; m_done = 1;
        end else if (m_capturing) begin
            if (strobe) begin
                grad_m[m_cnt] = int'(g); gvalid[m_cnt] = 1;
                frame_dop[m_cnt] = dop;
                m_cnt++;
                if (dop) m_edges++;
                if (m_cnt % 8 == 0) begin
                    edge_m[(m_cnt - 1) / 8] = pack(m_cnt - 8, 8);
                    evalid[(m_cnt - 1) / 8] = 1;
                end
                if (m_cnt == NPIX) begin m_capturing = 0; m_done = 1; end
            end else if (fin_rise) begin
                m_capturing = 0; m_flush = 1;
            end
        end else if (start) begin
            m_capturing = 1; m_done = 0; m_cnt = 0; m_edges = 0;
        end

        @(posedge CLK);
        #1;
        check("busy",  32'(bus.Busy), 32'(m_capturing | m_flush));
        check("done",  32'(bus.Done), 32'(m_done));
        check("pixcnt", 32'(bus.PixelCount), m_cnt);
        check("edgecnt", 32'(bus.EdgeCount), m_edges);
        if (v_rg) check("rdgrad", 32'(bus.RdGradient), exp_rg);
        if (v_re) check("rdedge", 32'(bus.RdEdgeByte), exp_re);
    endtask

    task automatic idle(input int ra, input int rea);
        step(0, 0, 2'd0, 0, 0, 0, 8'h00, ra, rea);
    endtask

    initial begin
        int nstrobe;
        int old7;
        logic [7:0] g;

        // Reset, then a contiguous full frame with Gradient=index, Dop=index[0].
        step(1, 0, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        check("rst_busy", 32'(bus.Busy), 0);
        check("rst_cnt",  32'(bus.PixelCount), 0);
        step(0, 1, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < NPIX; i++)
            step(0, ($urandom_range(0, 3) == 0), 2'd2, 1, 0, 1'(i & 1), 8'(i),
                 $urandom_range(0, NPIX - 1), $urandom_range(0, NBYTE - 1));
        idle(100, 5);
        check("full_done",  32'(bus.Done), 1);
        check("full_cnt",   32'(bus.PixelCount), NPIX);
        check("full_edges", 32'(bus.EdgeCount), NPIX / 2);
        check("grad100",    32'(bus.RdGradient), 100);
        check("edge5",      32'(bus.RdEdgeByte), 32'h55);

        // Gapped strobes: isReady toggles, SobelState=1 for 10 cycles.
        nstrobe = 0;
        step(0, 1, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        for (int c = 0; c < 1000 && m_capturing; c++) begin
            logic [1:0] ss;
            bit rdy;
            ss  = (c >= 20 && c < 30) ? 2'd1 : 2'd2;
            rdy = (c % 2 == 0);
            if (rdy && ss == 2'd2) nstrobe++;
            step(0, 0, ss, rdy, 0, 1'($urandom), 8'($urandom),
                 $urandom_range(0, NPIX - 1), $urandom_range(0, NBYTE - 1));
        end
        check("gap_done", 32'(bus.Done), 1);
        check("gap_cnt",  32'(bus.PixelCount), nstrobe);

        // Strobes while DONE are dropped.
        for (int i = 0; i < 20; i++)
            step(0, 0, 2'd2, 1, 0, 1, 8'hEE, i, i % NBYTE);
        check("done_hold", 32'(bus.PixelCount), NPIX);
        step(0, 1, 2'd2, 0, 0, 0, 8'h00, 0, 0);
        check("restart_done", 32'(bus.Done), 0);
        check("restart_cnt",  32'(bus.PixelCount), 0);

        // Short frame: 13 edge pixels, then Finish forces a flush of the partial byte.
        for (int i = 0; i < 13; i++)
            step(0, 0, 2'd2, 1, 0, 1, 8'($urandom), 0, 0);
        step(0, 0, 2'd2, 1, 1, 1, 8'h00, 0, 0);
        step(0, 0, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        idle(0, 1);
        check("short_done", 32'(bus.Done), 1);
        check("short_cnt",  32'(bus.PixelCount), 13);
        check("flush_byte", 32'(bus.RdEdgeByte), 32'hF8);

        // Reset in the middle of a frame, then recapture from address 0.
        step(0, 1, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 100; i++)
            step(0, 0, 2'd2, 1, 0, 1'($urandom), 8'($urandom), $urandom_range(0, NPIX - 1), 0);
        step(1, 0, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        check("abort_busy", 32'(bus.Busy), 0);
        check("abort_cnt",  32'(bus.PixelCount), 0);
        check("abort_done", 32'(bus.Done), 0);
        step(0, 1, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 2'd2, 1, 0, 0, 8'hA0 + 8'(i), 0, 0);
        idle(0, 0);
        check("overwrite0", 32'(bus.RdGradient), 32'hA0);

        // Read and write of pixel 7 in the same cycle: old data, then new data.
        old7 = grad_m[7];
        step(0, 0, 2'd2, 1, 0, 1, 8'h31, 7, 0);
        step(0, 0, 2'd2, 1, 0, 1, 8'h32, 7, 0);
        step(0, 0, 2'd2, 1, 0, 1, 8'h77, 7, 0);
        check("rw7_old", 32'(bus.RdGradient), old7);
        step(0, 0, 2'd0, 0, 0, 0, 8'h00, 7, 0);
        check("rw7_new", 32'(bus.RdGradient), 32'h77);

        for (int c = 0; c < 400 && m_capturing; c++) begin
            g = 8'($urandom);
            step(0, 0, 2'd2, 1'($urandom), 0, 1'($urandom), g,
                 $urandom_range(0, NPIX - 1), $urandom_range(0, NBYTE - 1));
        end
        idle(0, 0);
        check("final_done", 32'(bus.Done), 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/sobel_result_sink.md
Name: sobel_result_sink

Overview:
- Receive end of the Sobel output stream. Captures Dop (edge bit) and Gradient for every valid output pixel.
- Stores gradients in an on-chip frame RAM and packs edge bits MSB-first into bytes in a second RAM.
- Provides a registered read port so a host, or the bench, can dump the result frame after Done.
- Replaces the bench-side file capture, so edge/gradient results live in hardware.

Parameters:
- IMG_W, 256, pixels per row
- IMG_H, 256, rows per frame
- ADDR_W, 16, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  arm capture of one frame (level sampled in IDLE/DONE)
- SobelState  in  2  Sobel current state; value 2 = output phase
- isReady  in  1  Sobel output pipeline valid
- Finish  in  1  Sobel frame-complete flag
- Dop  in  1  edge bit for current pixel
- Gradient  in  8  gradient magnitude for current pixel
- RdAddr  in  ADDR_W  gradient read address (pixel index)
- RdEdgeAddr  in  ADDR_W-3  edge-byte read address
- RdGradient  out  8  gradient at RdAddr, 1-cycle latency
- RdEdgeByte  out  8  packed edge byte at RdEdgeAddr, 1-cycle latency
- Busy  out  1  high in CAPTURE and FLUSH
- Done  out  1  frame stored; held until next Start or Reset
- PixelCount  out  ADDR_W+1  pixels captured this frame
- EdgeCount  out  ADDR_W+1  captured pixels with Dop=1

Behaviour:
- Reset values:
  - Busy=0, Done=0, PixelCount=0, EdgeCount=0, RdGradient=0, RdEdgeByte=0.
  - Internal shift byte and bit index are 0; state is IDLE.
  - RAM contents are not cleared.
- Capture strobe: cap = isReady & ~Finish & (SobelState==2), evaluated at the rising edge. The strobe is honoured only in CAPTURE.
- FSM states: IDLE, CAPTURE, FLUSH, DONE.
  - IDLE: Start=1 -> CAPTURE. Clears PixelCount, EdgeCount, shift byte and bit index.
  - CAPTURE, per cap cycle:
    - Gradient RAM[PixelCount] <= Gradient.
    - Shift byte bit (7 - bitidx) <= Dop.
    - PixelCount increments; EdgeCount increments when Dop=1.
    - When bitidx==7, the full byte (including the current Dop) is written to EdgeRAM[PixelCount>>3] in that same cycle, and the shift byte clears.
  - CAPTURE exit:
    - The cycle PixelCount reaches IMG_W*IMG_H (after the increment) -> DONE.
    - If Finish rises earlier (short frame) -> FLUSH.
  - FLUSH: one cycle. If bitidx!=0, write the partial byte (unused LSBs = 0) to EdgeRAM[PixelCount>>3]. Then -> DONE.
  - DONE:
    - Done=1; PixelCount and EdgeCount are frozen.
    - Start=1 -> CAPTURE, with the same clears as IDLE; Done drops the next cycle.
- Start is ignored in CAPTURE and FLUSH.
- cap strobes arriving while not in CAPTURE, or after IMG_W*IMG_H pixels, are dropped. There are no RAM writes and counters do not change.
- Read port is usable in every state.
  - RdGradient/RdEdgeByte are registered: address at edge N -> data after edge N+1.
  - Read and write to the same address in the same cycle return the old RAM contents.
- Reset mid-operation: return to IDLE next edge and drop any partial edge byte. RAM words already written remain.
- Counter width ADDR_W+1 holds IMG_W*IMG_H exactly; no wrap is possible.

Test Plan:
- Reset, Start, 65536 cap cycles with Gradient = index[7:0] and Dop = index[0] -> Done=1, PixelCount=65536, EdgeCount=32768, RdAddr=300 gives RdGradient=0x2C, RdEdgeAddr=5 gives RdEdgeByte=0x55.
- Start with cap gapped (isReady toggling every cycle, and SobelState=1 for 10 cycles) -> only cycles with SobelState=2 & isReady stored; PixelCount matches the strobe count exactly.
- IMG_W=IMG_H=4, 13 strobes with Dop=1, then Finish=1 -> FLUSH writes EdgeRAM[1]=0xF8; Done=1; PixelCount=13.
- Reset asserted after 100 strobes -> next cycle Busy=0, PixelCount=0, Done=0. A new Start then overwrites from address 0.
- In DONE, drive 20 extra cap strobes and assert Start=0 -> no count change, RAM unchanged. Then Start=1 -> Done=0 next cycle and PixelCount=0.
- Simultaneous write and read at address 7 during CAPTURE -> RdGradient shows the previous content; a re-read next cycle shows the new Gradient.
